writeback_ctrl: RTL and testbench



---
 rtl/writeback_pkg.sv | 22 ++
 rtl/writeback_fifo.sv | 72 +++++++
 rtl/writeback_ctrl.sv | 138 +++++++++++++
 tb/tb_writeback_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/writeback_pkg.sv
// Shared types and default sizes for the register-file writeback path.
package writeback_pkg;

  localparam int unsigned DefRegsPtrW = 5;
  localparam int unsigned DefRegsNum  = 32;
  localparam int unsigned DefRegSize  = 32;
  localparam int unsigned X0_IDX      = 0;

  typedef struct packed {
    logic [DefRegsPtrW-1:0] rd;
    logic [DefRegSize-1:0]  data;
  } wb_req_t;

  // Source feeding the write port in a given cycle.
  typedef enum logic [1:0] {
    SelNone,
    SelLsu,
    SelFifo,
    SelAlu
  } wb_sel_e;

endpackage

// File: rtl/writeback_fifo.sv
// Small circular buffer for ALU results waiting on the regfile write port.
module writeback_fifo
  import writeback_pkg::*;
#(
  parameter type         req_t      = wb_req_t,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  req_t push_data_i,
  input  logic pop_i,
  output req_t head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [CntW-1:0] count_q, count_d;
  req_t            mem_q [FIFO_DEPTH];

  logic push_ok, pop_ok;

  assign full_o  = (count_q == FIFO_DEPTH[CntW-1:0]);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rptr_q];

  // Guard against misuse so the pointers never run past the occupancy.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (push_ok) begin
      wptr_d = wptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; the count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/writeback_ctrl.sv
// Arbitrates ALU and LSU results onto the single regfile write port and
// tracks pending destination registers for decode hazard checks.
module writeback_ctrl
  import writeback_pkg::*;
#(
  parameter int unsigned REGS_PTR_W = DefRegsPtrW,
  parameter int unsigned REGS_NUM   = DefRegsNum,
  parameter int unsigned REG_SIZE   = DefRegSize,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_vld,
  input  logic [REGS_PTR_W-1:0] issue_rd,
  input  logic                  alu_vld,
  output logic                  alu_rdy,
  input  logic [REGS_PTR_W-1:0] alu_rd,
  input  logic [REG_SIZE-1:0]   alu_data,
  input  logic                  lsu_vld,
  input  logic [REGS_PTR_W-1:0] lsu_rd,
  input  logic [REG_SIZE-1:0]   lsu_data,
  output logic                  we,
  output logic [REGS_PTR_W-1:0] wa,
  output logic [REG_SIZE-1:0]   wd,
  output logic [REGS_NUM-1:0]   busy_vec
);

  // Sized from this instance's parameters rather than the package defaults.
  typedef struct packed {
    logic [REGS_PTR_W-1:0] rd;
    logic [REG_SIZE-1:0]   data;
  } req_t;

  localparam logic [REGS_PTR_W-1:0] X0Rd = X0_IDX[REGS_PTR_W-1:0];

  logic    fifo_full, fifo_empty;
  logic    fifo_push, fifo_pop;
  req_t    fifo_head;
  req_t    alu_req, lsu_req, sel_req;
  wb_sel_e sel;
  logic    alu_fire;

  logic                  we_q, we_d;
  logic [REGS_PTR_W-1:0] wa_q, wa_d;
  logic [REG_SIZE-1:0]   wd_q, wd_d;
  logic [REGS_NUM-1:0]   busy_q, busy_d;

  assign alu_req  = '{rd: alu_rd, data: alu_data};
  assign lsu_req  = '{rd: lsu_rd, data: lsu_data};
  assign alu_rdy  = ~fifo_full & ~rst;
  assign alu_fire = alu_vld & alu_rdy;

  writeback_fifo #(
    .req_t      (req_t),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (fifo_push),
    .push_data_i (alu_req),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // LSU is never back-pressured, so it always wins; buffered ALU results
  // drain before a fresh ALU result may bypass, preserving ALU order.
  always_comb begin
    sel       = SelNone;
    fifo_pop  = 1'b0;
    fifo_push = 1'b0;
    if (lsu_vld) begin
      sel       = SelLsu;
      fifo_push = alu_fire;
    end else if (!fifo_empty) begin
      sel       = SelFifo;
      fifo_pop  = 1'b1;
      fifo_push = alu_fire;
    end else if (alu_fire) begin
      sel = SelAlu;
    end
  end

  always_comb begin
    sel_req = '0;
    unique case (sel)
      SelLsu:  sel_req = lsu_req;
      SelFifo: sel_req = fifo_head;
      SelAlu:  sel_req = alu_req;
      default: sel_req = '0;
    endcase
  end

  always_comb begin
    we_d = 1'b0;
    wa_d = wa_q;
    wd_d = wd_q;
    if (sel != SelNone) begin
      we_d = (sel_req.rd != X0Rd);
      wa_d = sel_req.rd;
      wd_d = sel_req.data;
    end
  end

  // Clear on the regfile write, then set on issue so a same-cycle reissue
  // of the register being written keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (we_q) begin
      busy_d[wa_q] = 1'b0;
    end
    if (issue_vld && (issue_rd != X0Rd)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[X0_IDX] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
      busy_q <= '0;
    end else begin
      we_q   <= we_d;
      wa_q   <= wa_d;
      wd_q   <= wd_d;
      busy_q <= busy_d;
    end
  end

  assign we       = we_q;
  assign wa       = wa_q;
  assign wd       = wd_q;
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_writeback_ctrl.sv
// Directed vector table plus a randomised ordering/coverage run for writeback_ctrl.
module tb_writeback_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_vld = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        alu_vld = 1'b0;
  logic        alu_rdy;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        lsu_vld = 1'b0;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] busy_vec;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  writeback_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .issue_vld (issue_vld),
    .issue_rd  (issue_rd),
    .alu_vld   (alu_vld),
    .alu_rdy   (alu_rdy),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_vld   (lsu_vld),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .busy_vec  (busy_vec)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [4:0]  ird;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        rdy;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] busy;
  } vec_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  vec_t vecs[$];
  wr_t  pending[$];

  function automatic vec_t mk(input logic r, input logic iv, input logic [4:0] ird,
                              input logic av, input logic [4:0] ard, input logic [31:0] ad,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                              input logic rdy, input logic ewe, input logic [4:0] ewa,
                              input logic [31:0] ewd, input logic [31:0] ebusy);
    vec_t v;
    v.rst = r;  v.iv = iv;  v.ird = ird;
    v.av = av;  v.ard = ard; v.ad = ad;
    v.lv = lv;  v.lrd = lrd; v.ld = ld;
    v.rdy = rdy; v.we = ewe; v.wa = ewa; v.wd = ewd; v.busy = ebusy;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Random-phase scoreboard state.
  logic exp_lsu;
  wr_t  lsu_exp;
  logic hold;

  task automatic rnd_check(input int cyc);
    logic ok;
    ok = 1'b1;
    if (exp_lsu) begin
      if (lsu_exp.rd != 5'd0) ok = we && (wa == lsu_exp.rd) && (wd == lsu_exp.data);
      else ok = !we;
    end else if (we) begin
      if (pending.size() == 0) begin
        ok = 1'b0;
      end else begin
        ok = (wa == pending[0].rd) && (wd == pending[0].data);
        void'(pending.pop_front());
      end
    end
    total++;
    if (ok) passed++;
    else $display("FAIL rnd_write cyc %0d: got we=%0b wa=%0d wd=0x%0h, expected lsu=%0b lsu_rd=%0d alu_head=%0d",
                  cyc, we, wa, wd, exp_lsu, lsu_exp.rd,
                  (pending.size() != 0) ? int'(pending[0].rd) : -1);
  endtask

  task automatic rnd_record();
    #1;
    if (lsu_vld && lsu_rd != 5'd0) begin
      foreach (pending[k]) begin
        assert (pending[k].rd != lsu_rd) else $error("WAW protocol violation on rd %0d", lsu_rd);
      end
    end
    if (alu_vld && alu_rdy && alu_rd != 5'd0) pending.push_back('{rd: alu_rd, data: alu_data});
    hold    = alu_vld && !alu_rdy;
    exp_lsu = lsu_vld;
    lsu_exp = '{rd: lsu_rd, data: lsu_data};
  endtask

  initial begin
    //      rst iv ird   av ard    ad            lv lrd    ld         rdy we wa     wd            busy
    vecs.push_back(mk(1, 0, 5'd0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,   0, 0, 5'd0,  32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 5'd0, 1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,   1, 1, 5'd5,  32'hDEADBEEF, 32'h0));
    vecs.push_back(mk(0, 0, 5'd0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,   1, 0, 5'd5,  32'hDEADBEEF, 32'h0));
    // LSU owns the port for 4 cycles while the ALU streams 10, 11, 12.
    vecs.push_back(mk(0, 0, 5'd0, 1, 5'd10, 32'hA10,      1, 5'd1,  32'h101, 1, 1, 5'd1,  32'h101,      32'h0));
    vecs.push_back(mk(0, 0, 5'd0, 1, 5'd11, 32'hA11,      1, 5'd2,  32'h102, 1, 1, 5'd2,  32'h102,      32'h0));
    vecs.push_back(mk(0, 0, 5'd0, 1, 5'd12, 32'hA12,      1, 5'd3,  32'h103, 0, 1, 5'd3,  32'h103,      32'h0));
    vecs.push_back(mk(0, 0, 5'd0, 1, 5'd12, 32'hA12,      1, 5'd4,  32'h104, 0, 1, 5'd4,  32'h104,      32'h0));
    vecs.push_back(mk(0, 0, 5'd0, 1, 5'd12, 32'hA12,      0, 5'd0,  32'h0,   0, 1, 5'd10, 32'hA10,      32'h0));
    vecs.push_back(mk(0, 0, 5'd0, 1, 5'd12, 32'hA12,      0, 5'd0,  32'h0,   1, 1, 5'd11, 32'hA11,      32'h0));
    vecs.push_back(mk(0, 0, 5'd0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,   1, 1, 5'd12, 32'hA12,      32'h0));
    vecs.push_back(mk(0, 0, 5'd0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,   1, 0, 5'd12, 32'hA12,      32'h0));
    // x0 result and x0 issue.
    vecs.push_back(mk(0, 1, 5'd0, 1, 5'd0,  32'h1234,     0, 5'd0,  32'h0,   1, 0, 5'd0,  32'h1234,     32'h0));
    // Scoreboard set / clear / set-wins.
    vecs.push_back(mk(0, 1, 5'd7, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,   1, 0, 5'd0,  32'h1234,     32'h80));
    vecs.push_back(mk(0, 0, 5'd0, 1, 5'd7,  32'h77,       0, 5'd0,  32'h0,   1, 1, 5'd7,  32'h77,       32'h80));
    vecs.push_back(mk(0, 0, 5'd0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,   1, 0, 5'd7,  32'h77,       32'h0));
    vecs.push_back(mk(0, 1, 5'd7, 1, 5'd7,  32'h78,       0, 5'd0,  32'h0,   1, 1, 5'd7,  32'h78,       32'h80));
    vecs.push_back(mk(0, 1, 5'd7, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,   1, 0, 5'd7,  32'h78,       32'h80));
    vecs.push_back(mk(0, 0, 5'd0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,   1, 0, 5'd7,  32'h78,       32'h80));
    // Fill the FIFO behind the LSU with busy 3,4 set, then reset.
    vecs.push_back(mk(0, 1, 5'd3, 1, 5'd3,  32'h33,       1, 5'd20, 32'h200, 1, 1, 5'd20, 32'h200,      32'h88));
    vecs.push_back(mk(0, 1, 5'd4, 1, 5'd4,  32'h44,       1, 5'd21, 32'h201, 1, 1, 5'd21, 32'h201,      32'h98));
    vecs.push_back(mk(1, 0, 5'd0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,   0, 0, 5'd0,  32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 5'd0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,   1, 0, 5'd0,  32'h0,        32'h0));
    vecs.push_back(mk(0, 0, 5'd0, 0, 5'd0,  32'h0,        0, 5'd0,  32'h0,   1, 0, 5'd0,  32'h0,        32'h0));

    foreach (vecs[i]) begin
      rst = vecs[i].rst;  issue_vld = vecs[i].iv; issue_rd = vecs[i].ird;
      alu_vld = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].ad;
      lsu_vld = vecs[i].lv; lsu_rd = vecs[i].lrd; lsu_data = vecs[i].ld;
      #1;
      check("alu_rdy", i, {31'd0, alu_rdy}, {31'd0, vecs[i].rdy});
      step();
      check("we", i, {31'd0, we}, {31'd0, vecs[i].we});
      check("wa", i, {27'd0, wa}, {27'd0, vecs[i].wa});
      check("wd", i, wd, vecs[i].wd);
      check("busy_vec", i, busy_vec, vecs[i].busy);
    end

    // Random traffic: ALU rd in 0..15, LSU rd in {0,16..31}, so no WAW inversion.
    issue_vld = 1'b0;
    exp_lsu   = 1'b0;
    lsu_exp   = '0;
    hold      = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (!hold) begin
        alu_vld  = 1'($urandom_range(0, 1));
        alu_rd   = 5'($urandom_range(0, 15));
        alu_data = $urandom;
      end
      begin
        int r;
        r = int'($urandom_range(15, 31));
        lsu_vld  = ($urandom_range(0, 9) < 3);
        lsu_rd   = (r == 15) ? 5'd0 : 5'(r);
        lsu_data = $urandom;
      end
      rnd_record();
      step();
      rnd_check(cyc);
    end

    // Drain: keep a stalled ALU result stable until accepted, then go idle.
    lsu_vld = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (!hold) alu_vld = 1'b0;
      rnd_record();
      step();
      rnd_check(10000 + cyc);
    end
    check("pending_after_drain", 0, pending.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
